// File: rtl/zork_pkg.sv
// rtl/zork_pkg.sv - direction/state encodings, grid defaults, secret cell and wall map for the maze player
package zork_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'b00,
    DIR_E = 2'b01,
    DIR_S = 2'b10,
    DIR_W = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    MOVE    = 3'd2,
    BLOCK   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int DEF_GRID_MAX_X = 9;
  localparam int DEF_GRID_MAX_Y = 9;
  localparam int DEF_START_X    = 0;
  localparam int DEF_START_Y    = 0;
  localparam int DEF_SECRET_X   = 0;
  localparam int DEF_SECRET_Y   = 6;

  // Row index is y, bit index is x; the secret cell's own bit is set but never consulted.
  localparam logic [15:0] WALL_MAP [16] = '{
    16'h0000,  // y=0
    16'h0008,  // y=1
    16'h003C,  // y=2
    16'h0000,  // y=3
    16'h0080,  // y=4
    16'h0001,  // y=5
    16'h0011,  // y=6
    16'h0000,  // y=7
    16'h0100,  // y=8
    16'h0000,  // y=9
    16'h0000,
    16'h0000,
    16'h0000,
    16'h0000,
    16'h0000,
    16'h0000
  };

endpackage

// File: rtl/maze_wall_rom.sv
// rtl/maze_wall_rom.sv - combinational (x,y) to blocked-bit lookup into the static wall map
module maze_wall_rom
  import zork_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       blocked
);

  assign blocked = WALL_MAP[y][x];

endmodule

// File: rtl/player_position_ctrl.sv
// rtl/player_position_ctrl.sv - maze player position tracker with bounds/wall/secret-cell checks
// MOVE_SYNC_EN: adds 2-flop synchronizers on move_req_i and dir_i ahead of edge detection.
module player_position_ctrl
  import zork_pkg::*;
#(
  parameter int GRID_MAX_X = DEF_GRID_MAX_X,
  parameter int GRID_MAX_Y = DEF_GRID_MAX_Y,
  parameter int START_X    = DEF_START_X,
  parameter int START_Y    = DEF_START_Y,
  parameter int SECRET_X   = DEF_SECRET_X,
  parameter int SECRET_Y   = DEF_SECRET_Y
) (
  input  logic       clk_50MHz_i,
  input  logic       rst_async_la_i,
  input  logic       move_req_i,
  input  logic [1:0] dir_i,
  input  logic       wall_open_i,
  output logic [3:0] posx_o,
  output logic [3:0] posy_o,
  output logic       enable_move_o,
  output logic       blocked_o,
  output logic       busy_o
);

  logic       req_s;
  logic [1:0] dir_s;

`ifdef MOVE_SYNC_EN
  logic [1:0] req_sync;
  logic [1:0] dir_sync1;
  logic [1:0] dir_sync2;

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      req_sync  <= '0;
      dir_sync1 <= '0;
      dir_sync2 <= '0;
    end else begin
      req_sync  <= {req_sync[0], move_req_i};
      dir_sync1 <= dir_i;
      dir_sync2 <= dir_sync1;
    end
  end

  assign req_s = req_sync[1];
  assign dir_s = dir_sync2;
`else
  assign req_s = move_req_i;
  assign dir_s = dir_i;
`endif

  state_t state;
  state_t state_nxt;
  dir_t   dir_q;
  logic   req_hist;
  logic   req_rise;

  assign req_rise = req_s & ~req_hist;

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      req_hist <= 1'b0;
      dir_q    <= DIR_N;
    end else begin
      req_hist <= req_s;
      if (state == IDLE && req_rise) dir_q <= dir_t'(dir_s);
    end
  end

  // 5-bit signed target so that stepping off x=0 or y=0 goes negative instead of wrapping.
  logic signed [4:0] tx;
  logic signed [4:0] ty;

  always_comb begin
    tx = $signed({1'b0, posx_o});
    ty = $signed({1'b0, posy_o});
    case (dir_q)
      DIR_N: ty = ty - 5'sd1;
      DIR_E: tx = tx + 5'sd1;
      DIR_S: ty = ty + 5'sd1;
      DIR_W: tx = tx - 5'sd1;
    endcase
  end

  logic map_blocked;
  logic in_grid;
  logic is_secret;
  logic move_ok;

  maze_wall_rom u_wall_rom (
    .x       (tx[3:0]),
    .y       (ty[3:0]),
    .blocked (map_blocked)
  );

  assign in_grid   = !tx[4] && !ty[4] && (int'(tx) <= GRID_MAX_X) && (int'(ty) <= GRID_MAX_Y);
  assign is_secret = (tx == 5'(SECRET_X)) && (ty == 5'(SECRET_Y));
  assign move_ok   = in_grid && (is_secret ? wall_open_i : !map_blocked);

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (req_rise) state_nxt = CHECK;
      CHECK:       state_nxt = move_ok ? MOVE : BLOCK;
      MOVE, BLOCK: state_nxt = RELEASE;
      RELEASE:     if (!req_s) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
  end

  // Pulses and position are registered off the CHECK decision so they line up with MOVE/BLOCK.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      posx_o        <= 4'(START_X);
      posy_o        <= 4'(START_Y);
      enable_move_o <= 1'b0;
      blocked_o     <= 1'b0;
    end else begin
      enable_move_o <= (state == CHECK) && move_ok;
      blocked_o     <= (state == CHECK) && !move_ok;
      if (state == CHECK && move_ok) begin
        posx_o <= tx[3:0];
        posy_o <= ty[3:0];
      end
    end
  end

endmodule

// File: tb/tb_player_position_ctrl.sv
// tb/tb_player_position_ctrl.sv - self-checking bench for player_position_ctrl
module tb_player_position_ctrl;

  logic       clk_50MHz_i    = 1'b0;
  logic       rst_async_la_i = 1'b0;
  logic       move_req_i     = 1'b0;
  logic [1:0] dir_i          = 2'b00;
  logic       wall_open_i    = 1'b0;
  logic [3:0] posx_o;
  logic [3:0] posy_o;
  logic       enable_move_o;
  logic       blocked_o;
  logic       busy_o;

`ifdef MOVE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  player_position_ctrl dut (
    .clk_50MHz_i    (clk_50MHz_i),
    .rst_async_la_i (rst_async_la_i),
    .move_req_i     (move_req_i),
    .dir_i          (dir_i),
    .wall_open_i    (wall_open_i),
    .posx_o         (posx_o),
    .posy_o         (posy_o),
    .enable_move_o  (enable_move_o),
    .blocked_o      (blocked_o),
    .busy_o         (busy_o)
  );

  always #10 clk_50MHz_i = ~clk_50MHz_i;

  int n_pass   = 0;
  int n_total  = 0;
  int edge_cnt = 0;

  always @(posedge clk_50MHz_i) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Model: player position plus the timeline of the move in flight, in clock-edge numbers.
  int mx = 0, my = 0;
  bit trk = 0;
  int t_pulse = -100, t_busy_s = -100, t_idle = -100;
  int t_ox = 0, t_oy = 0, t_nx = 0, t_ny = 0;
  bit t_acc = 0;
  int n_en = 0, n_blk = 0;

  function automatic bit is_wall(input int x, input int y);
    return (x == 3 && y == 1) || (y == 2 && x >= 2 && x <= 5) || (x == 7 && y == 4) ||
           (x == 0 && y == 5) || (x == 4 && y == 6) || (x == 8 && y == 8);
  endfunction

  always @(negedge clk_50MHz_i) begin
    if (trk) begin
      chk("posx", posx_o, (edge_cnt >= t_pulse) ? t_nx : t_ox);
      chk("posy", posy_o, (edge_cnt >= t_pulse) ? t_ny : t_oy);
      chk("enable_move", enable_move_o, (edge_cnt == t_pulse && t_acc) ? 1 : 0);
      chk("blocked", blocked_o, (edge_cnt == t_pulse && !t_acc) ? 1 : 0);
      chk("busy", busy_o, (edge_cnt >= t_busy_s && edge_cnt < t_idle) ? 1 : 0);
      if (enable_move_o) n_en++;
      if (blocked_o) n_blk++;
    end
  end

  task automatic do_move(input logic [1:0] d, input int hold, input logic wo, input string tag);
    int k, r, tx, ty;
    bit acc;
    @(negedge clk_50MHz_i);
    #1;
    k  = edge_cnt + 1;
    tx = mx + ((d == 2'b01) ? 1 : (d == 2'b11) ? -1 : 0);
    ty = my + ((d == 2'b10) ? 1 : (d == 2'b00) ? -1 : 0);
    acc = (tx >= 0) && (tx <= 9) && (ty >= 0) && (ty <= 9) &&
          ((tx == 0 && ty == 6) ? wo : !is_wall(tx, ty));
    t_ox = mx; t_oy = my;
    t_nx = acc ? tx : mx;
    t_ny = acc ? ty : my;
    t_acc    = acc;
    t_busy_s = k + LAT;
    t_pulse  = k + LAT + 1;
    r        = k + hold - 1;
    t_idle   = (k + LAT + 3 > r + 1 + LAT) ? k + LAT + 3 : r + 1 + LAT;
    n_en = 0; n_blk = 0;
    dir_i = d; wall_open_i = wo; move_req_i = 1'b1;
    repeat (hold) @(posedge clk_50MHz_i);
    #1 move_req_i = 1'b0;
    repeat (t_idle - edge_cnt + 2) @(posedge clk_50MHz_i);
    #1;
    chk({tag, "_enable_pulses"}, n_en, acc ? 1 : 0);
    chk({tag, "_blocked_pulses"}, n_blk, acc ? 0 : 1);
    mx = t_nx; my = t_ny;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_50MHz_i);
    chk("rst_posx", posx_o, 0);
    chk("rst_posy", posy_o, 0);
    chk("rst_enable", enable_move_o, 0);
    chk("rst_blocked", blocked_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_async_la_i = 1'b1;
    @(negedge clk_50MHz_i);
    #1 trk = 1;

    do_move(2'b11, 2, 1'b0, "west_at_origin");
    do_move(2'b00, 2, 1'b0, "north_at_origin");
    chk("origin_kept_x", posx_o, 0);
    chk("origin_kept_y", posy_o, 0);

    do_move(2'b01, 3, 1'b0, "east_from_origin");
    chk("east_lit_x", posx_o, 1);
    chk("east_lit_y", posy_o, 0);

    do_move(2'b10, 1, 1'b0, "south1");
    do_move(2'b10, 1, 1'b0, "south2");
    do_move(2'b01, 2, 1'b0, "wall_map");
    chk("wall_map_lit_x", posx_o, 1);
    chk("wall_map_lit_y", posy_o, 2);
    for (int i = 0; i < 4; i++) do_move(2'b10, 2, 1'b0, "south_run");
    chk("at_1_6_x", posx_o, 1);
    chk("at_1_6_y", posy_o, 6);

    do_move(2'b11, 2, 1'b0, "secret_closed");
    chk("secret_closed_x", posx_o, 1);
    chk("secret_closed_y", posy_o, 6);
    do_move(2'b11, 2, 1'b1, "secret_open");
    chk("secret_open_x", posx_o, 0);
    chk("secret_open_y", posy_o, 6);
    do_move(2'b01, 2, 1'b1, "leave_secret");

    do_move(2'b01, 50, 1'b0, "held_button");
    chk("held_lit_x", posx_o, 2);
    chk("held_lit_y", posy_o, 6);

    // Reset while the move sits in CHECK: position snaps to start and no pulse follows.
    @(negedge clk_50MHz_i);
    #1 trk = 0;
    dir_i = 2'b01; move_req_i = 1'b1;
    repeat (LAT + 1) @(posedge clk_50MHz_i);
    #1;
    chk("busy_in_check", busy_o, 1);
    rst_async_la_i = 1'b0;
    move_req_i = 1'b0;
    #1;
    chk("midrst_posx", posx_o, 0);
    chk("midrst_posy", posy_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_enable", enable_move_o, 0);
    chk("midrst_blocked", blocked_o, 0);
    repeat (2) @(negedge clk_50MHz_i);
    rst_async_la_i = 1'b1;
    repeat (8) begin
      @(negedge clk_50MHz_i);
      chk("post_rst_enable", enable_move_o, 0);
      chk("post_rst_blocked", blocked_o, 0);
      chk("post_rst_posx", posx_o, 0);
      chk("post_rst_posy", posy_o, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
